// File: rtl/acc_requant_int8_if.sv
// Accumulator-in / activation-out stream bundle for the requantizer.
interface acc_requant_int8_if #(
  parameter int ACC_W  = 32,
  parameter int DATA_W = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [ACC_W-1:0]  in_acc;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;

  modport master (output in_valid, in_acc, out_ready,
                  input  in_ready, out_valid, out_data, out_last);
  modport slave  (input  in_valid, in_acc, out_ready,
                  output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/acc_requant_int8.sv
// INT32 accumulator -> INT8 activation: scale multiply, rounding shift, zero point, ReLU, saturate.
// Capture, multiply, shift and clamp registers form one pipeline that holds as a whole on stall.
module acc_requant_int8 #(
  parameter int ACC_W   = 32,
  parameter int DATA_W  = 8,
  parameter int MULT_W  = 16,
  parameter int SHIFT_W = 6,
  parameter int VEC_LEN = 16,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [MULT_W-1:0] cfg_mult,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  input  logic signed [DATA_W-1:0] cfg_zp,
  input  logic                     cfg_relu,
  acc_requant_int8_if.slave        io,
  input  logic                     sat_clr,
  output logic [CNT_W-1:0]         sat_count,
  output logic                     busy
);
  localparam int PW     = ACC_W + MULT_W;
  localparam int IDX_W  = $clog2(VEC_LEN);
  localparam int STAGES = 3;
  localparam logic signed [PW+1:0] DMAX = (PW+2)'(2**(DATA_W-1) - 1);
  localparam logic signed [PW+1:0] DMIN = -(PW+2)'(2**(DATA_W-1));

  // Each element carries its own vector's config so mixed-vector pipeline contents stay correct.
  typedef struct packed {
    logic [ACC_W-1:0]   acc;
    logic [MULT_W-1:0]  mult;
    logic [SHIFT_W-1:0] shift;
    logic [DATA_W-1:0]  zp;
    logic               relu;
    logic               last;
  } cap_t;

  typedef struct packed {
    logic [PW-1:0]      p;
    logic [SHIFT_W-1:0] shift;
    logic [DATA_W-1:0]  zp;
    logic               relu;
    logic               last;
  } mul_t;

  typedef struct packed {
    logic [PW:0]       q;
    logic [DATA_W-1:0] zp;
    logic              relu;
    logic              last;
  } shf_t;

  logic [STAGES:0]          vld_pipe;
  logic                     stall, accept, first, sat3;
  logic [IDX_W-1:0]         cnt;
  logic [MULT_W-1:0]        sh_mult;
  logic [SHIFT_W-1:0]       sh_shift;
  logic [DATA_W-1:0]        sh_zp;
  logic                     sh_relu;
  cap_t                     s0, s0_nxt;
  mul_t                     s1, s1_nxt;
  shf_t                     s2, s2_nxt;
  logic [DATA_W-1:0]        d3, out_q;
  logic                     last_q;

  assign stall        = vld_pipe[STAGES] & ~io.out_ready;
  assign accept       = io.in_valid & ~stall;
  assign first        = (cnt == '0);
  assign io.in_ready  = ~stall;
  assign io.out_valid = vld_pipe[STAGES];
  assign io.out_data  = out_q;
  assign io.out_last  = last_q;
  assign busy         = |vld_pipe;

  // First element of a vector uses live cfg; the rest use the shadow taken at that element.
  always_comb begin
    s0_nxt.acc   = io.in_acc;
    s0_nxt.mult  = first ? cfg_mult  : sh_mult;
    s0_nxt.shift = first ? cfg_shift : sh_shift;
    s0_nxt.zp    = first ? cfg_zp    : sh_zp;
    s0_nxt.relu  = first ? cfg_relu  : sh_relu;
    s0_nxt.last  = (cnt == IDX_W'(VEC_LEN-1));
  end

  always_comb begin
    s1_nxt.p     = PW'($signed(s0.acc)) * PW'($signed(s0.mult));
    s1_nxt.shift = s0.shift;
    s1_nxt.zp    = s0.zp;
    s1_nxt.relu  = s0.relu;
    s1_nxt.last  = s0.last;
  end

  // One extra bit of headroom keeps the rounding add from overflowing.
  always_comb begin
    int                 sh;
    logic signed [PW:0] ext, half;
    sh = int'(s1.shift);
    if (sh > PW-1) sh = PW-1;
    ext  = (PW+1)'($signed(s1.p));
    half = '0;
    s2_nxt.q = ext;
    if (sh != 0) begin
      half     = (PW+1)'(1) << (sh-1);
      s2_nxt.q = (ext + half) >>> sh;
    end
    s2_nxt.zp   = s1.zp;
    s2_nxt.relu = s1.relu;
    s2_nxt.last = s1.last;
  end

  always_comb begin
    logic signed [PW:0]   qr;
    logic signed [PW+1:0] r;
    qr   = (s2.relu && s2.q[PW]) ? '0 : s2.q;
    r    = (PW+2)'(qr) + (PW+2)'($signed(s2.zp));
    sat3 = 1'b0;
    d3   = r[DATA_W-1:0];
    if (r > DMAX) begin
      d3   = {1'b0, {(DATA_W-1){1'b1}}};
      sat3 = 1'b1;
    end else if (r < DMIN) begin
      d3   = {1'b1, {(DATA_W-1){1'b0}}};
      sat3 = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      cnt       <= '0;
      sh_mult   <= '0;
      sh_shift  <= '0;
      sh_zp     <= '0;
      sh_relu   <= 1'b0;
      s0        <= '0;
      s1        <= '0;
      s2        <= '0;
      out_q     <= '0;
      last_q    <= 1'b0;
      sat_count <= '0;
    end else begin
      if (accept) begin
        cnt <= (cnt == IDX_W'(VEC_LEN-1)) ? '0 : cnt + 1'b1;
        if (first) begin
          sh_mult  <= cfg_mult;
          sh_shift <= cfg_shift;
          sh_zp    <= cfg_zp;
          sh_relu  <= cfg_relu;
        end
      end
      if (!stall) begin
        vld_pipe <= {vld_pipe[STAGES-1:0], accept};
        if (accept)      s0 <= s0_nxt;
        if (vld_pipe[0]) s1 <= s1_nxt;
        if (vld_pipe[1]) s2 <= s2_nxt;
        if (vld_pipe[2]) begin
          out_q  <= d3;
          last_q <= s2.last;
        end
      end
      if (sat_clr)
        sat_count <= '0;
      else if (!stall && vld_pipe[2] && sat3 && !(&sat_count))
        sat_count <= sat_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_acc_requant_int8.sv
// Directed bench for acc_requant_int8: arithmetic model + scoreboard, plus literal expectations.
module tb_acc_requant_int8;
  localparam int ACC_W = 32, DATA_W = 8, MULT_W = 16, SHIFT_W = 6, VEC_LEN = 16, CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [MULT_W-1:0] cfg_mult;
  logic [SHIFT_W-1:0]       cfg_shift;
  logic signed [DATA_W-1:0] cfg_zp;
  logic                     cfg_relu, sat_clr, busy;
  logic [CNT_W-1:0]         sat_count;

  acc_requant_int8_if #(.ACC_W(ACC_W), .DATA_W(DATA_W)) bus ();

  acc_requant_int8 #(.ACC_W(ACC_W), .DATA_W(DATA_W), .MULT_W(MULT_W), .SHIFT_W(SHIFT_W),
                     .VEC_LEN(VEC_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp),
    .cfg_relu(cfg_relu), .io(bus), .sat_clr(sat_clr), .sat_count(sat_count), .busy(busy));

  always #5 clk = ~clk;

  typedef struct { int data; bit last; bit sat; } exp_t;
  int   checks = 0, errors = 0;
  exp_t expq[$];
  int   got_d[$];
  bit   got_l[$];
  int   m_cnt = 0, m_mult, m_shift, m_zp, m_sat = 0;
  bit   m_relu, prev_stall = 0, prev_l, toggle_en = 0;
  int   prev_d;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Requant rule in plain integer arithmetic.
  function automatic void model(input longint acc, input longint mult, input int shift,
                                input int zp, input bit relu, output int d, output bit sat);
    longint p, q, r;
    int s;
    p = acc * mult;
    s = (shift > ACC_W+MULT_W-1) ? ACC_W+MULT_W-1 : shift;
    if (s == 0) q = p;
    else        q = (p + (longint'(1) << (s-1))) >>> s;
    if (relu && q < 0) q = 0;
    r   = q + zp;
    sat = (r > 127) || (r < -128);
    d   = (r > 127) ? 127 : (r < -128) ? -128 : int'(r);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int   d;
    bit   s;
    if (!rst_n) begin
      expq.delete();
      prev_stall = 0;
      m_cnt = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, prev_d);
        chk("stall_last", bus.out_last, prev_l);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out: got %0d expected no output", bus.out_data);
        end else begin
          e = expq.pop_front();
          chk("sb_data", bus.out_data, e.data);
          chk("sb_last", bus.out_last, e.last);
          if (e.sat) m_sat++;
          got_d.push_back(int'(bus.out_data));
          got_l.push_back(bus.out_last);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_d = int'(bus.out_data);
      prev_l = bus.out_last;
      if (bus.in_valid && bus.in_ready) begin
        if (m_cnt == 0) begin
          m_mult = int'(cfg_mult); m_shift = int'(cfg_shift);
          m_zp = int'(cfg_zp); m_relu = cfg_relu;
        end
        model(longint'(bus.in_acc), longint'(m_mult), m_shift, m_zp, m_relu, d, s);
        e.data = d; e.last = (m_cnt == VEC_LEN-1); e.sat = s;
        expq.push_back(e);
        m_cnt = (m_cnt == VEC_LEN-1) ? 0 : m_cnt + 1;
      end
    end
  end

  always @(posedge clk) if (toggle_en) begin
    #1 bus.out_ready = ~bus.out_ready;
  end

  task automatic send(input int acc);
    int n = 0;
    bit ok;
    bus.in_valid = 1'b1;
    bus.in_acc = acc;
    do begin
      @(negedge clk); ok = bus.in_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 100);
    if (!ok) begin checks++; errors++; $display("FAIL send_timeout: got no accept expected accept"); end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || expq.size() != 0) && n < 300) begin @(posedge clk); #1; n++; end
    if (n >= 300) begin checks++; errors++; $display("FAIL drain_timeout: got busy expected idle"); end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_sat = 0;
    got_d.delete();
    got_l.delete();
  endtask

  task automatic set_cfg(input int mult, input int shift, input int zp, input bit relu);
    cfg_mult = MULT_W'(mult); cfg_shift = SHIFT_W'(shift); cfg_zp = DATA_W'(zp); cfg_relu = relu;
  endtask

  initial begin
    int d, nl;
    bit s;
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int d, nl;
    bit s;
    bus.in_valid = 0; bus.in_acc = 0; bus.out_ready = 1; sat_clr = 0;
    set_cfg(1, 0, 0, 0);
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sat", sat_count, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_last", bus.out_last, 0);

    model(5, 3, 2, 0, 0, d, s);    chk("model_rnd_pos", d, 4);
    model(-5, 3, 2, 0, 0, d, s);   chk("model_rnd_neg", d, -4);
    model(200, 1, 0, -10, 1, d, s); chk("model_relu_sat", d, 127);

    // Saturation and first-element latency
    do_reset();
    set_cfg(1, 0, 0, 0);
    send(100);
    @(posedge clk); #1;
    @(posedge clk); #1; chk("lat_k2_valid", bus.out_valid, 0);
    @(posedge clk); #1; chk("lat_k3_valid", bus.out_valid, 1); chk("lat_k3_data", bus.out_data, 100);
    send(200); send(-200);
    drain();
    chk("sat_n", got_d.size(), 3);
    chk("sat_d0", got_d[0], 100); chk("sat_d1", got_d[1], 127); chk("sat_d2", got_d[2], -128);
    chk("sat_count2", sat_count, 2);
    chk("sat_model", sat_count, m_sat);

    // Rounding, then shift clamp
    do_reset();
    set_cfg(3, 2, 0, 0);
    send(5); send(-5); send(2); send(0);
    drain();
    chk("rnd_n", got_d.size(), 4);
    chk("rnd_d0", got_d[0], 4); chk("rnd_d1", got_d[1], -4);
    chk("rnd_d2", got_d[2], 2); chk("rnd_d3", got_d[3], 0);
    do_reset();
    set_cfg(1, 63, 0, 0);
    send(-1);
    drain();
    chk("shift63_n", got_d.size(), 1);
    chk("shift63_d", got_d[0], 0);

    // ReLU with zero point
    do_reset();
    set_cfg(1, 0, -10, 1);
    send(-50); send(20); send(200);
    drain();
    chk("relu_n", got_d.size(), 3);
    chk("relu_d0", got_d[0], -10); chk("relu_d1", got_d[1], 10); chk("relu_d2", got_d[2], 127);
    chk("relu_sat", sat_count, 1);

    // Backpressure with alternating out_ready
    do_reset();
    set_cfg(1, 0, 0, 0);
    toggle_en = 1;
    for (int i = 0; i < 32; i++) send(i);
    drain();
    toggle_en = 0;
    @(posedge clk); #2 bus.out_ready = 1;
    chk("bp_n", got_d.size(), 32);
    for (int i = 0; i < 32; i++) chk("bp_order", got_d[i], i);
    nl = 0;
    foreach (got_l[i]) nl += int'(got_l[i]);
    chk("bp_nlast", nl, 2);
    chk("bp_last15", got_l[15], 1); chk("bp_last31", got_l[31], 1);

    // Mid-vector config change only applies from the next vector
    do_reset();
    set_cfg(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) send(i + 1);
    cfg_mult = 2;
    for (int i = 5; i < 21; i++) send(i + 1);
    drain();
    chk("cfg_n", got_d.size(), 21);
    chk("cfg_d5", got_d[5], 6); chk("cfg_d15", got_d[15], 16); chk("cfg_d16", got_d[16], 34);

    // sat_clr coincident with a saturating element loading the output stage
    do_reset();
    set_cfg(1, 0, 0, 0);
    send(300);
    @(posedge clk); #1;
    @(posedge clk); #1; sat_clr = 1;
    @(posedge clk); #1; sat_clr = 0;
    chk("satclr_same", sat_count, 0);
    drain();
    chk("satclr_hold", sat_count, 0);
    m_sat = 0;
    send(300);
    drain();
    chk("satclr_after", sat_count, 1);
    chk("satclr_model", sat_count, m_sat);

    // Asynchronous reset with data in flight
    do_reset();
    set_cfg(1, 0, 0, 0);
    bus.out_ready = 0;
    send(200); send(200); send(200);
    repeat (3) @(posedge clk); #1;
    chk("pre_rst_sat", sat_count, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_sat", sat_count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", bus.in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    bus.out_ready = 1; m_sat = 0; got_d.delete(); got_l.delete();
    for (int i = 0; i < 16; i++) send(i);
    drain();
    chk("arst_n", got_d.size(), 16);
    nl = 0;
    foreach (got_l[i]) nl += int'(got_l[i]);
    chk("arst_nlast", nl, 1);
    chk("arst_last15", got_l[15], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/acc_requant_int8.md
Name: acc_requant_int8

Overview:
- Drain-side consumer of the INT32 accumulator stream produced by the systolic array's MAC columns.
- Converts each signed accumulator back to an INT8 activation: fixed-point scale multiply, rounding right shift, zero-point add, optional ReLU, saturation.
- Three-stage valid/ready pipeline with backpressure and a per-vector element counter that flags vector boundaries.
- Sits between the array output and the activation write-back buffer.

Parameters:
- ACC_W, 32, accumulator input width (signed)
- DATA_W, 8, output activation width (signed)
- MULT_W, 16, requant multiplier width (signed)
- SHIFT_W, 6, right-shift amount width (unsigned)
- VEC_LEN, 16, elements per output vector (>=2)
- CNT_W, 16, saturation event counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_mult  in  MULT_W  signed scale multiplier
- cfg_shift  in  SHIFT_W  right-shift amount
- cfg_zp  in  DATA_W  signed output zero point
- cfg_relu  in  1  1 = clamp negative scaled values to 0 before zero-point add
- in_valid  in  1  accumulator valid
- in_ready  out  1  block can accept
- in_acc  in  ACC_W  signed accumulator value
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  signed INT8 result
- out_last  out  1  result is last element of a vector
- sat_clr  in  1  synchronous clear of sat_count
- sat_count  out  CNT_W  number of saturated results, sticky at all-ones
- busy  out  1  any pipeline stage holds valid data

Behaviour:
- Reset (async, rst_n=0): all stage valids=0, out_valid=0, out_data=0, out_last=0, element counter=0, sat_count=0, busy=0, shadow config=0. in_ready=1 out of reset.
- Handshake: transfer on valid&ready at a rising edge. stall = out_valid & ~out_ready. The whole pipeline holds on stall; in_ready = ~stall (combinational). out_valid/out_data/out_last stay stable while stalled.
- Latency: an element accepted at edge k is presented at edge k+3 with no stall. Sustained throughput is 1 element/cycle. Bubbles propagate as invalid stages.
- Config shadowing: cfg_* are latched into shadow registers when an element is accepted with element counter==0. All elements of a vector use that vector's shadow values. cfg changes mid-vector take effect at the next vector's first element.
- S1: p = in_acc * mult, signed, full ACC_W+MULT_W bits.
- S2: effective shift s = min(cfg_shift, ACC_W+MULT_W-1).
  - s==0: q = p.
  - Otherwise: q = (p + 2^(s-1)) >>> s. Arithmetic shift, computed at width ACC_W+MULT_W+1 so the rounding add cannot overflow. This rounds half toward +inf.
- S3:
  - If relu and q<0, q = 0.
  - r = q + zp, sign-extended with no wrap.
  - out_data = clamp(r, -2^(DATA_W-1), 2^(DATA_W-1)-1).
  - sat flag = clamp was active.
- Element counter: increments on each input accept and wraps VEC_LEN-1 -> 0. Its value travels with the element. out_last=1 for the element with index VEC_LEN-1.
- sat_count: increments by 1 when a saturated element loads into S3. Holds at all-ones. sat_clr has priority: with simultaneous clear and increment, the result is 0.
- busy = OR of the three stage valids.
- Reset mid-stream: in-flight data is discarded and the counter returns to 0. The next accepted element is index 0.

Test Plan:
- Saturation: mult=1, shift=0, zp=0, relu=0; acc 100, 200, -200 -> out 100, 127, -128; sat_count=2; 3-cycle latency checked.
- Rounding: mult=3, shift=2; acc 5, -5, 2, 0 -> out 4, -4, 2, 0. Also shift=63 with acc=-1, mult=1 -> out 0 (s clamped to 47).
- ReLU + zero point: mult=1, shift=0, zp=-10, relu=1; acc -50, 20, 200 -> out -10, 10, 127 (the last saturates).
- Backpressure: stream 32 values acc=i with out_ready toggling 1,0,1,0. All 32 arrive in order with none dropped or duplicated; out_last only on the 16th and 32nd; outputs are stable while stalled.
- Config mid-vector: mult=1 for element 0, switch to mult=2 at element 5 -> elements 0..15 scaled by 1; element 16 onward scaled by 2. sat_clr asserted in the same cycle as a saturating element -> sat_count=0.
- Async reset: assert rst_n=0 with 3 elements in flight -> out_valid=0 and sat_count=0 immediately; after release, stream 16 values -> out_last only on the 16th.
